// File: rtl/parall_master.sv
// Bus master for the 16-bit asynchronous parallel register interface (cs_n/rd_n/wr_n, tri-state data).
// Define PARALL_WR_VERIFY_EN to follow every write with an automatic readback of the same address.
module parall_master #(
  parameter int unsigned SETUP_CYC  = 4,
  parameter int unsigned STROBE_CYC = 8,
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned TURN_CYC   = 2
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        req,
  input  logic        req_wr,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [7:0]  addr,
  inout  wire  [15:0] data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_TURN   = 3'd4
  } state_t;

`ifdef PARALL_WR_VERIFY_EN
  localparam logic VERIFY = 1'b1;
`else
  localparam logic VERIFY = 1'b0;
`endif

  localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
  localparam logic [7:0] TURN_LD   = 8'(TURN_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_wr_q, bus_wr_d;
  logic        rb_q, rb_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        req_ready_q, req_ready_d;
  logic        cs_n_q, cs_n_d;
  logic        rd_n_q, rd_n_d;
  logic        wr_n_q, wr_n_d;
  logic        drive_q, drive_d;

  // A write bus cycle answers only after its readback when verification is built in.
  logic rsp_due_s, readback_s, err_s;
  assign rsp_due_s  = !(VERIFY && bus_wr_q);
  assign readback_s = VERIFY && bus_wr_q;
  assign err_s      = VERIFY && rb_q && (cap_q != wdata_q);

  // Next-state, phase counter, transaction latches and registered bus/response outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_wr_d    = bus_wr_q;
    rb_d        = rb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cap_d       = cap_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req && req_ready_q) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          bus_wr_d = req_wr;
          rb_d     = 1'b0;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
        end else begin
          cnt_d = 8'd0;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = S_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
          if (!bus_wr_q) begin
            cap_d = data;
          end else begin
            cap_d = cap_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = S_TURN;
          cnt_d   = TURN_LD;
          if (rsp_due_s) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus_wr_q ? rsp_rdata_q : cap_q;
            rsp_err_d   = err_s;
          end else begin
            rsp_valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_TURN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (readback_s) begin
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
          bus_wr_d = 1'b0;
          rb_d     = 1'b1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        cnt_d    = 8'd0;
        bus_wr_d = 1'b0;
        rb_d     = 1'b0;
      end
    endcase
    // Bus pins follow the upcoming state so they change on the same edge as the FSM.
    cs_n_d      = !(state_d == S_SETUP || state_d == S_STROBE || state_d == S_HOLD);
    rd_n_d      = !(state_d == S_STROBE && !bus_wr_d);
    wr_n_d      = !(state_d == S_STROBE && bus_wr_d);
    drive_d     = !cs_n_d && bus_wr_d;
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers; reset aborts any transaction and releases the bus immediately.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_wr_q    <= 1'b0;
      rb_q        <= 1'b0;
      addr_q      <= 8'd0;
      wdata_q     <= 16'd0;
      cap_q       <= 16'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'd0;
      rsp_err_q   <= 1'b0;
      req_ready_q <= 1'b0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_wr_q    <= bus_wr_d;
      rb_q        <= rb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cap_q       <= cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      req_ready_q <= req_ready_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      drive_q     <= drive_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign cs_n      = cs_n_q;
  assign rd_n      = rd_n_q;
  assign wr_n      = wr_n_q;
  assign addr      = addr_q;
  assign data      = drive_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_parall_master.sv
// Bench for parall_master: random requests scored against a register-file model, a bus-timing
// monitor, a second instance with 1/1/1/1 timing, and an asynchronous reset mid-write.
`timescale 1ns/1ps
module tb_parall_master;
  localparam int S = 4, ST = 8, H = 4, T = 2;
`ifdef PARALL_WR_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  // Counting the accept cycle as cycle 1, the response lands in cycle 1+S+ST+H+1 (18 by default).
  localparam int LAT  = 1 + S + ST + H;
  localparam int SPAN = LAT + T;
  localparam int RB   = S + ST + H + T;

  typedef struct { logic [15:0] rdata; logic err; int acc; int lat; } exp_t;
  typedef struct { logic w; logic [7:0] a; logic [15:0] wd; } bus_t;

  logic sclk = 1'b0;
  always #10 sclk = ~sclk;
  logic rst = 1'b0;
  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;
  int total = 0;
  int bad = 0;

  logic        req = 1'b0, req_wr = 1'b0;
  logic [7:0]  req_addr = 8'd0;
  logic [15:0] req_wdata = 16'd0;
  logic        req_ready, rsp_valid, rsp_err, cs_n, rd_n, wr_n;
  logic [15:0] rsp_rdata;
  logic [7:0]  addr;
  wire  [15:0] data;

  parall_master u_dut (
    .sclk(sclk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .data(data)
  );

  // Register-file slave; address 9 silently drops writes.
  logic [15:0] sl_mem [256] = '{default: 16'h0000};
  always @(posedge sclk) if (!cs_n && !wr_n && addr != 8'd9) sl_mem[addr] <= data;
  assign data = (!cs_n && !rd_n) ? sl_mem[addr] : 16'hzzzz;

  logic        freq = 1'b0, freq_wr = 1'b0;
  logic [7:0]  freq_addr = 8'd0;
  logic [15:0] freq_wdata = 16'd0;
  logic        freq_ready, frsp_valid, frsp_err, fcs_n, frd_n, fwr_n;
  logic [15:0] frsp_rdata;
  logic [7:0]  faddr;
  wire  [15:0] fdata;

  parall_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(1)) u_fast (
    .sclk(sclk), .rst(rst), .req(freq), .req_wr(freq_wr), .req_addr(freq_addr),
    .req_wdata(freq_wdata), .req_ready(freq_ready), .rsp_valid(frsp_valid),
    .rsp_rdata(frsp_rdata), .rsp_err(frsp_err), .cs_n(fcs_n), .rd_n(frd_n), .wr_n(fwr_n),
    .addr(faddr), .data(fdata)
  );

  logic [15:0] fsl_mem [256] = '{default: 16'h0000};
  always @(posedge sclk) if (!fcs_n && !fwr_n) fsl_mem[faddr] <= fdata;
  assign fdata = (!fcs_n && !frd_n) ? fsl_mem[faddr] : 16'hzzzz;

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model state
  logic [15:0] ref_mem [256] = '{default: 16'h0000};
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] fref [256] = '{default: 16'h0000};
  logic [15:0] flast = 16'h0000;
  int prev_acc = -1, prev_span = 0, fprev = -1, fspan = 0;
  exp_t expq[$];
  bus_t btq[$];
  logic [15:0] fexp[$];

  // Response scoreboard for the main instance
  always @(negedge sclk) begin
    exp_t e;
    if (!rst && rsp_valid) begin
      chk("rsp_expected", int'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
        chk("rsp_err", int'(rsp_err), int'(e.err));
        chk("rsp_latency", cyc - e.acc, e.lat);
      end
    end
  end

  // Response scoreboard for the 1/1/1/1 instance
  always @(negedge sclk) begin
    if (!rst && frsp_valid) begin
      chk("fast_rsp_expected", int'(fexp.size() != 0), 1);
      if (fexp.size() != 0) chk("fast_rsp_rdata", int'(frsp_rdata), int'(fexp.pop_front()));
    end
  end

  // Bus-cycle monitor: strobe width, cycle length, turnaround gap, data ownership
  bus_t cur;
  int win_len = 0, wr_low = 0, rd_low = 0, gap = 0;
  always @(negedge sclk) begin
    if (rst) begin
      win_len = 0; wr_low = 0; rd_low = 0; gap = T;
    end else if (!cs_n) begin
      if (win_len == 0) begin
        chk("cs_n_turn_gap", int'(gap >= T), 1);
        chk("bus_cycle_expected", int'(btq.size() != 0), 1);
        if (btq.size() != 0) cur = btq.pop_front();
      end
      win_len++; gap = 0;
      if (!wr_n) wr_low++;
      if (!rd_n) rd_low++;
      chk("bus_addr", int'(addr), int'(cur.a));
      if (cur.w) chk("wr_data_driven", int'(data === cur.wd), 1);
      else if (rd_n) chk("rd_data_released", int'(data === 16'hzzzz), 1);
    end else begin
      chk("idle_data_released", int'(data === 16'hzzzz), 1);
      if (win_len > 0) begin
        chk("bus_cycle_len", win_len, S + ST + H);
        chk("strobe_len", cur.w ? wr_low : rd_low, ST);
        chk("wrong_strobe", cur.w ? rd_low : wr_low, 0);
      end
      win_len = 0; wr_low = 0; rd_low = 0; gap++;
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d, input bit b2b);
    exp_t e;
    bus_t bt;
    int n = 0;
    req = 1'b1; req_wr = w; req_addr = a; req_wdata = d;
    @(negedge sclk);
    while (!req_ready && n < 100) begin @(negedge sclk); n++; end
    chk("accept_timeout", int'(req_ready), 1);
    if (!req_ready) begin req = 1'b0; return; end
    if (prev_acc >= 0) begin
      if (b2b) chk("accept_spacing", cyc - prev_acc, prev_span);
      else chk("accept_spacing_min", int'(cyc - prev_acc >= prev_span), 1);
    end
    e.acc = cyc; e.lat = LAT; e.err = 1'b0;
    bt.w = w; bt.a = a; bt.wd = d;
    btq.push_back(bt);
    if (w) begin
      if (a != 8'd9) ref_mem[a] = d;
      if (VFY) begin
        e.rdata = ref_mem[a]; e.err = (ref_mem[a] != d); e.lat = LAT + RB;
        last_rd = ref_mem[a];
        bt.w = 1'b0; btq.push_back(bt);
        prev_span = SPAN + RB;
      end else begin
        e.rdata = last_rd;
        prev_span = SPAN;
      end
    end else begin
      e.rdata = ref_mem[a]; last_rd = ref_mem[a];
      prev_span = SPAN;
    end
    expq.push_back(e);
    prev_acc = cyc;
    @(posedge sclk); #1;
    req = 1'b0;
  endtask

  task automatic fissue(input logic w, input logic [7:0] a, input logic [15:0] d);
    int n = 0;
    freq = 1'b1; freq_wr = w; freq_addr = a; freq_wdata = d;
    @(negedge sclk);
    while (!freq_ready && n < 50) begin @(negedge sclk); n++; end
    chk("fast_accept_timeout", int'(freq_ready), 1);
    if (!freq_ready) begin freq = 1'b0; return; end
    if (fprev >= 0) chk("fast_accept_spacing", cyc - fprev, fspan);
    fprev = cyc;
    if (w) begin
      fref[a] = d;
      fexp.push_back(VFY ? d : flast);
      if (VFY) flast = d;
      fspan = VFY ? 9 : 5;
    end else begin
      fexp.push_back(fref[a]); flast = fref[a];
      fspan = 5;
    end
    @(posedge sclk); #1;
    freq = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || fexp.size() != 0) && n < 500) begin @(negedge sclk); n++; end
    chk("drain_timeout", int'(n < 500), 1);
    repeat (3) @(negedge sclk);
    @(posedge sclk); #1;
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    #5 rst = 1'b1;
    repeat (3) @(negedge sclk);
    chk("reset_cs_n", int'(cs_n), 1);
    chk("reset_rd_n", int'(rd_n), 1);
    chk("reset_wr_n", int'(wr_n), 1);
    chk("reset_addr", int'(addr), 0);
    chk("reset_data_z", int'(data === 16'hzzzz), 1);
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_rdata", int'(rsp_rdata), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    chk("reset_fast_cs_n", int'(fcs_n), 1);
    @(posedge sclk); #1 rst = 1'b0;
    @(posedge sclk); @(negedge sclk);
    chk("ready_after_reset", int'(req_ready), 1);
    @(posedge sclk); #1;

    // Directed cases
    issue(1'b1, 8'd3, 16'hA5A5, 1'b0);
    drain();
    issue(1'b1, 8'd3, 16'h1234, 1'b0);
    issue(1'b0, 8'd3, 16'h0000, 1'b1);
    issue(1'b1, 8'd1, 16'hBEEF, 1'b1);
    issue(1'b0, 8'd1, 16'h0000, 1'b1);
    drain();
    issue(1'b1, 8'd9, 16'h00FF, 1'b0);
    issue(1'b0, 8'd9, 16'h0000, 1'b1);
    drain();

    // Randomized traffic, mixing back-to-back and spaced requests
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge sclk);
        #1;
        issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom), 1'b0);
      end else begin
        issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom), 1'b1);
      end
    end
    drain();

    // Minimum timing instance, request held high throughout
    fissue(1'b1, 8'd20, 16'h1111);
    fissue(1'b0, 8'd20, 16'h0000);
    fissue(1'b1, 8'd21, 16'h2222);
    fissue(1'b0, 8'd21, 16'h0000);
    fissue(1'b0, 8'd20, 16'h0000);
    fissue(1'b1, 8'd22, 16'h3333);
    drain();

    // Asynchronous reset in the middle of a write strobe
    issue(1'b1, 8'd5, 16'h5A5A, 1'b0);
    k = 0;
    while (wr_n && k < 50) begin @(negedge sclk); k++; end
    chk("strobe_reached", int'(wr_n), 0);
    @(negedge sclk);
    #5 rst = 1'b1;
    #1;
    chk("midrst_cs_n", int'(cs_n), 1);
    chk("midrst_wr_n", int'(wr_n), 1);
    chk("midrst_data_z", int'(data === 16'hzzzz), 1);
    chk("midrst_rsp_valid", int'(rsp_valid), 0);
    chk("midrst_req_ready", int'(req_ready), 0);
    expq.delete(); btq.delete(); fexp.delete();
    prev_acc = -1; last_rd = 16'h0000; fprev = -1; flast = 16'h0000;
    repeat (2) @(posedge sclk);
    #1 rst = 1'b0;
    @(posedge sclk); @(negedge sclk);
    chk("ready_after_midrst", int'(req_ready), 1);
    repeat (25) @(negedge sclk);
    @(posedge sclk); #1;
    issue(1'b0, 8'd5, 16'h0000, 1'b0);
    drain();

    chk("outstanding_rsp", expq.size(), 0);
    chk("outstanding_bus", btq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
